// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I(+MUL) pipeline.
// Contents: ALU op codes, forward-select codes, branch funct3 values,
// the MUL FSM state encoding and the forward-mux helper.
package riscv_pkg;

  // ALU operation codes driven by decode
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Forward select codes; 2'b11 is unused and falls back to the register file
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Conditional branch funct3 values
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Iterative multiplier states
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Pick the operand source named by a forward select
  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] reg_val,
                                          input logic [31:0] mem_val,
                                          input logic [31:0] wb_val);
    logic [31:0] res;
    case (sel)
      FWD_MEM: res = mem_val;
      FWD_WB:  res = wb_val;
      default: res = reg_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per cycle,
// low 32 bits of the product kept. Operands are captured on start so the
// caller may let its sources change while the multiply runs.
module iter_multiplier
  import riscv_pkg::*;
#(
  parameter int MUL_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic        idle_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o
);

  localparam logic [5:0] LAST_CNT = 6'(MUL_ITERS - 1);

  mul_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;

  // Next-state logic: abort always returns to IDLE, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: begin
        if (start_i && !abort_i) state_d = MUL_BUSY;
        else                     state_d = MUL_IDLE;
      end
      MUL_BUSY: begin
        if (abort_i)                state_d = MUL_IDLE;
        else if (cnt_q == LAST_CNT) state_d = MUL_DONE;
        else                        state_d = MUL_BUSY;
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  // Datapath: capture operands on start, then one shift-add step per BUSY cycle
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (state_q == MUL_IDLE && start_i && !abort_i) begin
      cnt_d    = 6'd0;
      acc_d    = 32'd0;
      mcand_d  = opa_i;
      mplier_d = opb_i;
    end else if (state_q == MUL_BUSY) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      else             acc_d = acc_q;
      mcand_d  = {mcand_q[30:0], 1'b0};
      mplier_d = {1'b0, mplier_q[31:1]};
      cnt_d    = cnt_q + 6'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign idle_o    = (state_q == MUL_IDLE);
  assign busy_o    = (state_q == MUL_BUSY);
  assign done_o    = (state_q == MUL_DONE);
  assign product_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forward muxes, ALU, branch resolution, the iterative MUL
// hookup and the EX/MEM pipeline register.
module ex_stage
  import riscv_pkg::*;
#(
  parameter int MUL_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_valid,
  input  logic [4:0]  EX_RD,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic [31:0] EX_rs1_data,
  input  logic [31:0] EX_rs2_data,
  input  logic [31:0] EX_imm,
  input  logic [31:0] EX_pc,
  input  logic [3:0]  EX_alu_op,
  input  logic        EX_alu_src,
  input  logic        EX_is_branch,
  input  logic [2:0]  EX_funct3,
  input  logic        EX_is_mul,
  input  logic [1:0]  forwardA,
  input  logic [1:0]  forwardB,
  input  logic [31:0] MEM_fwd_data,
  input  logic [31:0] WB_fwd_data,
  input  logic        flush,
  output logic        ex_stall,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        MEM_valid,
  output logic        MEM_RegWrite,
  output logic        MEM_MemRead,
  output logic        MEM_MemWrite,
  output logic [4:0]  MEM_RD,
  output logic [31:0] MEM_alu_result,
  output logic [31:0] MEM_store_data
);

  logic [31:0] opa_s, fwdb_s, opb_s, alu_res_s;
  logic        br_cond_s;
  logic        mul_start_s, mul_idle_s, mul_busy_s, mul_done_s;
  logic [31:0] mul_product_s;

  // Control fields of the multiply in flight, written with its product
  logic [4:0]  mul_rd_q, mul_rd_d;
  logic        mul_rw_q, mul_rw_d;

  logic        mem_valid_q, mem_valid_d;
  logic        mem_rw_q, mem_rw_d;
  logic        mem_mr_q, mem_mr_d;
  logic        mem_mw_q, mem_mw_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic [31:0] mem_res_q, mem_res_d;
  logic [31:0] mem_st_q, mem_st_d;

  assign opa_s  = fwd_mux(forwardA, EX_rs1_data, MEM_fwd_data, WB_fwd_data);
  assign fwdb_s = fwd_mux(forwardB, EX_rs2_data, MEM_fwd_data, WB_fwd_data);
  assign opb_s  = EX_alu_src ? EX_imm : fwdb_s;

  // ALU: unknown op codes produce zero
  always_comb begin
    alu_res_s = 32'd0;
    case (EX_alu_op)
      ALU_ADD:   alu_res_s = opa_s + opb_s;
      ALU_SUB:   alu_res_s = opa_s - opb_s;
      ALU_AND:   alu_res_s = opa_s & opb_s;
      ALU_OR:    alu_res_s = opa_s | opb_s;
      ALU_XOR:   alu_res_s = opa_s ^ opb_s;
      ALU_SLL:   alu_res_s = opa_s << opb_s[4:0];
      ALU_SRL:   alu_res_s = opa_s >> opb_s[4:0];
      ALU_SRA:   alu_res_s = $unsigned($signed(opa_s) >>> opb_s[4:0]);
      ALU_SLT:   alu_res_s = {31'd0, ($signed(opa_s) < $signed(opb_s))};
      ALU_SLTU:  alu_res_s = {31'd0, (opa_s < opb_s)};
      ALU_PASSB: alu_res_s = opb_s;
      default:   alu_res_s = 32'd0;
    endcase
  end

  // Branch condition always compares against the register operand, never imm
  always_comb begin
    br_cond_s = 1'b0;
    case (EX_funct3)
      F3_BEQ:  br_cond_s = (opa_s == fwdb_s);
      F3_BNE:  br_cond_s = (opa_s != fwdb_s);
      F3_BLT:  br_cond_s = ($signed(opa_s) < $signed(fwdb_s));
      F3_BGE:  br_cond_s = ($signed(opa_s) >= $signed(fwdb_s));
      F3_BLTU: br_cond_s = (opa_s < fwdb_s);
      F3_BGEU: br_cond_s = (opa_s >= fwdb_s);
      default: br_cond_s = 1'b0;
    endcase
  end

  assign branch_taken  = EX_valid & EX_is_branch & br_cond_s & ~flush;
  assign branch_target = EX_pc + EX_imm;

  assign mul_start_s = EX_valid & EX_is_mul & ~flush;
  assign ex_stall    = (mul_idle_s & mul_start_s) | mul_busy_s;

  iter_multiplier #(
    .MUL_ITERS(MUL_ITERS)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .start_i  (mul_start_s),
    .abort_i  (flush),
    .opa_i    (opa_s),
    .opb_i    (fwdb_s),
    .idle_o   (mul_idle_s),
    .busy_o   (mul_busy_s),
    .done_o   (mul_done_s),
    .product_o(mul_product_s)
  );

  // EX/MEM next value: bubble on flush/stall, product in DONE, else the instruction
  always_comb begin
    mem_valid_d = 1'b0;
    mem_rw_d    = 1'b0;
    mem_mr_d    = 1'b0;
    mem_mw_d    = 1'b0;
    mem_rd_d    = 5'd0;
    mem_res_d   = mem_res_q;
    mem_st_d    = mem_st_q;
    mul_rd_d    = mul_rd_q;
    mul_rw_d    = mul_rw_q;
    if (mul_idle_s && mul_start_s) begin
      mul_rd_d = EX_RD;
      mul_rw_d = EX_RegWrite;
    end else begin
      mul_rd_d = mul_rd_q;
    end
    if (flush || ex_stall) begin
      mem_valid_d = 1'b0;
    end else if (mul_done_s) begin
      mem_valid_d = 1'b1;
      mem_rw_d    = mul_rw_q & (mul_rd_q != 5'd0);
      mem_rd_d    = mul_rd_q;
      mem_res_d   = mul_product_s;
    end else if (EX_valid) begin
      mem_valid_d = 1'b1;
      mem_rw_d    = EX_RegWrite & (EX_RD != 5'd0);
      mem_mr_d    = EX_MemRead;
      mem_mw_d    = EX_MemWrite;
      mem_rd_d    = EX_RD;
      mem_res_d   = alu_res_s;
      mem_st_d    = fwdb_s;
    end else begin
      mem_valid_d = 1'b0;
    end
  end

  // EX/MEM register and latched MUL control fields
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_mr_q    <= 1'b0;
      mem_mw_q    <= 1'b0;
      mem_rd_q    <= 5'd0;
      mem_res_q   <= 32'd0;
      mem_st_q    <= 32'd0;
      mul_rd_q    <= 5'd0;
      mul_rw_q    <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_mr_q    <= mem_mr_d;
      mem_mw_q    <= mem_mw_d;
      mem_rd_q    <= mem_rd_d;
      mem_res_q   <= mem_res_d;
      mem_st_q    <= mem_st_d;
      mul_rd_q    <= mul_rd_d;
      mul_rw_q    <= mul_rw_d;
    end
  end

  assign MEM_valid      = mem_valid_q;
  assign MEM_RegWrite   = mem_rw_q;
  assign MEM_MemRead    = mem_mr_q;
  assign MEM_MemWrite   = mem_mw_q;
  assign MEM_RD         = mem_rd_q;
  assign MEM_alu_result = mem_res_q;
  assign MEM_store_data = mem_st_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with a scoreboard of expected EX/MEM contents.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_valid;
  logic [4:0]  EX_RD;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite;
  logic [31:0] EX_rs1_data, EX_rs2_data, EX_imm, EX_pc;
  logic [3:0]  EX_alu_op;
  logic        EX_alu_src, EX_is_branch, EX_is_mul;
  logic [2:0]  EX_funct3;
  logic [1:0]  forwardA, forwardB;
  logic [31:0] MEM_fwd_data, WB_fwd_data;
  logic        flush;
  logic        ex_stall, branch_taken;
  logic [31:0] branch_target;
  logic        MEM_valid, MEM_RegWrite, MEM_MemRead, MEM_MemWrite;
  logic [4:0]  MEM_RD;
  logic [31:0] MEM_alu_result, MEM_store_data;

  typedef struct {
    logic        valid;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] st;
    logic        chk_st;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  ex_stage #(.MUL_ITERS(32)) dut (
    .clk(clk), .reset(reset), .EX_valid(EX_valid), .EX_RD(EX_RD),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_rs1_data(EX_rs1_data), .EX_rs2_data(EX_rs2_data), .EX_imm(EX_imm),
    .EX_pc(EX_pc), .EX_alu_op(EX_alu_op), .EX_alu_src(EX_alu_src),
    .EX_is_branch(EX_is_branch), .EX_funct3(EX_funct3), .EX_is_mul(EX_is_mul),
    .forwardA(forwardA), .forwardB(forwardB), .MEM_fwd_data(MEM_fwd_data),
    .WB_fwd_data(WB_fwd_data), .flush(flush), .ex_stall(ex_stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .MEM_valid(MEM_valid), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_MemWrite(MEM_MemWrite), .MEM_RD(MEM_RD), .MEM_alu_result(MEM_alu_result),
    .MEM_store_data(MEM_store_data)
  );

  function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] r,
                                          input logic [31:0] m, input logic [31:0] w);
    if (sel == 2'b10)      return m;
    else if (sel == 2'b01) return w;
    else                   return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    EX_valid = 1'b0; EX_RD = 5'd0; EX_RegWrite = 1'b0; EX_MemRead = 1'b0;
    EX_MemWrite = 1'b0; EX_rs1_data = 32'd0; EX_rs2_data = 32'd0; EX_imm = 32'd0;
    EX_pc = 32'd0; EX_alu_op = 4'd0; EX_alu_src = 1'b0; EX_is_branch = 1'b0;
    EX_funct3 = 3'd0; EX_is_mul = 1'b0; forwardA = 2'b00; forwardB = 2'b00;
    flush = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_valid"}, {31'd0, MEM_valid}, {31'd0, e.valid});
      check({tag, "_rw"}, {31'd0, MEM_RegWrite}, {31'd0, e.rw});
      check({tag, "_mr"}, {31'd0, MEM_MemRead}, {31'd0, e.mr});
      check({tag, "_mw"}, {31'd0, MEM_MemWrite}, {31'd0, e.mw});
      check({tag, "_rd"}, {27'd0, MEM_RD}, {27'd0, e.rd});
      check({tag, "_res"}, MEM_alu_result, e.res);
      if (e.chk_st) check({tag, "_st"}, MEM_store_data, e.st);
    end
  endtask

  // Drive one single-cycle instruction, queue its expectation, clock it, compare
  task automatic issue_alu(input string tag, input logic [3:0] op,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic src,
                           input logic [1:0] fa, input logic [1:0] fb,
                           input logic [4:0] rd, input logic rw,
                           input logic mr, input logic mw, input logic [31:0] exp_res);
    exp_t e;
    clear_inputs();
    EX_valid = 1'b1; EX_alu_op = op; EX_rs1_data = rs1; EX_rs2_data = rs2;
    EX_imm = imm; EX_alu_src = src; forwardA = fa; forwardB = fb;
    EX_RD = rd; EX_RegWrite = rw; EX_MemRead = mr; EX_MemWrite = mw;
    e.valid = 1'b1; e.rw = rw & (rd != 5'd0); e.mr = mr; e.mw = mw; e.rd = rd;
    e.res = exp_res; e.st = fwd_ref(fb, rs2, MEM_fwd_data, WB_fwd_data); e.chk_st = 1'b1;
    sb_q.push_back(e);
    tick();
    pop_check(tag);
  endtask

  task automatic drive_mul(input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [1:0] fa, input logic [4:0] rd);
    clear_inputs();
    EX_valid = 1'b1; EX_is_mul = 1'b1; EX_rs1_data = rs1; EX_rs2_data = rs2;
    forwardA = fa; EX_RD = rd; EX_RegWrite = 1'b1;
  endtask

  initial begin
    int   n;
    int   bub;
    exp_t e;

    clear_inputs();
    MEM_fwd_data = 32'd7;
    WB_fwd_data  = 32'd9;
    reset = 1'b1;
    tick();
    tick();
    check("rst_valid", {31'd0, MEM_valid}, 32'd0);
    check("rst_rw", {31'd0, MEM_RegWrite}, 32'd0);
    check("rst_res", MEM_alu_result, 32'd0);
    check("rst_st", MEM_store_data, 32'd0);
    check("rst_stall", {31'd0, ex_stall}, 32'd0);
    reset = 1'b0;

    // Forwarding into operand A: rs1=5, MEM=7, WB=9, +1
    issue_alu("fwd_mem", 4'd0, 32'd5, 32'd0, 32'd1, 1'b1, 2'b10, 2'b00, 5'd1, 1'b1, 1'b0, 1'b0, 32'd8);
    issue_alu("fwd_wb",  4'd0, 32'd5, 32'd0, 32'd1, 1'b1, 2'b01, 2'b00, 5'd1, 1'b1, 1'b0, 1'b0, 32'd10);
    issue_alu("fwd_11",  4'd0, 32'd5, 32'd0, 32'd1, 1'b1, 2'b11, 2'b00, 5'd1, 1'b1, 1'b0, 1'b0, 32'd6);
    // Forwarding into operand B and store data never taking the immediate
    issue_alu("fwdb_wb", 4'd1, 32'd5, 32'd0, 32'd0, 1'b0, 2'b00, 2'b01, 5'd2, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    issue_alu("st_imm",  4'd0, 32'h100, 32'd3, 32'd4, 1'b1, 2'b00, 2'b10, 5'd0, 1'b0, 1'b0, 1'b1, 32'h104);

    // Signed/unsigned ALU behaviour with opA = all ones
    issue_alu("slt",  4'd8, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 2'b00, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0, 32'd1);
    issue_alu("sltu", 4'd9, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 2'b00, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0);
    issue_alu("sra",  4'd7, 32'hFFFF_FFFF, 32'd0, 32'd4, 1'b1, 2'b00, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    issue_alu("srl",  4'd6, 32'hFFFF_FFFF, 32'd0, 32'd4, 1'b1, 2'b00, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0FFF_FFFF);
    issue_alu("add0", 4'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 2'b00, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0);
    issue_alu("sub",  4'd1, 32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
    issue_alu("and",  4'd2, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 2'b00, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0, 32'hF000);
    issue_alu("or",   4'd3, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 2'b00, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0, 32'hFFF0);
    issue_alu("xor",  4'd4, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 2'b00, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0FF0);
    issue_alu("sll",  4'd5, 32'd3, 32'd0, 32'h21, 1'b1, 2'b00, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0, 32'd6);
    issue_alu("passb", 4'd10, 32'd3, 32'd0, 32'h1234_5000, 1'b1, 2'b00, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0, 32'h1234_5000);
    issue_alu("badop", 4'd11, 32'd3, 32'd0, 32'd5, 1'b1, 2'b00, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0);
    issue_alu("load", 4'd0, 32'h200, 32'd0, 32'd8, 1'b1, 2'b00, 2'b00, 5'd6, 1'b1, 1'b1, 1'b0, 32'h208);
    // x0 destination never writes
    issue_alu("x0", 4'd0, 32'd1, 32'd0, 32'd1, 1'b1, 2'b00, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0, 32'd2);

    // Branch resolution (combinational)
    clear_inputs();
    EX_valid = 1'b1; EX_is_branch = 1'b1; EX_funct3 = 3'b100;
    EX_rs1_data = 32'hFFFF_FFFF; EX_rs2_data = 32'd0; EX_pc = 32'h100; EX_imm = 32'hFFFF_FFF0;
    #1;
    check("blt_taken", {31'd0, branch_taken}, 32'd1);
    check("br_target", branch_target, 32'hF0);
    EX_funct3 = 3'b110; #1;
    check("bltu_taken", {31'd0, branch_taken}, 32'd0);
    EX_funct3 = 3'b101; #1;
    check("bge_taken", {31'd0, branch_taken}, 32'd0);
    EX_funct3 = 3'b111; #1;
    check("bgeu_taken", {31'd0, branch_taken}, 32'd1);
    EX_funct3 = 3'b010; #1;
    check("f3_010", {31'd0, branch_taken}, 32'd0);
    EX_funct3 = 3'b001; #1;
    check("bne_taken", {31'd0, branch_taken}, 32'd1);
    EX_funct3 = 3'b000; EX_rs1_data = 32'd0; #1;
    check("beq_taken", {31'd0, branch_taken}, 32'd1);
    flush = 1'b1; #1;
    check("br_flush", {31'd0, branch_taken}, 32'd0);
    EX_is_branch = 1'b0; flush = 1'b0;
    tick();
    check("bubble_after_flush_off", {31'd0, MEM_valid}, 32'd1);
    clear_inputs();
    tick();
    check("idle_bubble", {31'd0, MEM_valid}, 32'd0);

    // MUL via MEM forward; the forward source changes after issue
    MEM_fwd_data = 32'h0001_0000;
    drive_mul(32'd0, 32'h0001_0003, 2'b10, 5'd3);
    e.valid = 1'b1; e.rw = 1'b1; e.mr = 1'b0; e.mw = 1'b0; e.rd = 5'd3;
    e.res = 32'h0003_0000; e.st = 32'd0; e.chk_st = 1'b0;
    sb_q.push_back(e);
    #1;
    check("mul_issue_stall", {31'd0, ex_stall}, 32'd1);
    n = 0; bub = 0;
    while (ex_stall === 1'b1 && n < 100) begin
      n++;
      tick();
      if (n == 1) MEM_fwd_data = 32'hDEAD_BEEF;
      if (MEM_valid !== 1'b0) bub++;
    end
    check("mul_stall_cycles", n, 32'd33);
    check("mul_bubbles", bub, 32'd0);
    tick();
    pop_check("mul");
    MEM_fwd_data = 32'd7;
    issue_alu("after_mul", 4'd0, 32'd40, 32'd0, 32'd2, 1'b1, 2'b00, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0, 32'd42);

    // Flush at BUSY cycle 10 aborts the multiply
    drive_mul(32'h1234, 32'd5, 2'b00, 5'd7);
    tick();
    repeat (9) tick();
    check("busy_stall", {31'd0, ex_stall}, 32'd1);
    flush = 1'b1;
    tick();
    check("flush_stall", {31'd0, ex_stall}, 32'd0);
    check("flush_bubble", {31'd0, MEM_valid}, 32'd0);
    clear_inputs();
    bub = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (MEM_valid !== 1'b0) bub++;
    end
    check("flush_no_product", bub, 32'd0);

    // Flush coincident with issue: nothing starts
    drive_mul(32'd3, 32'd3, 2'b00, 5'd7);
    flush = 1'b1;
    #1;
    check("flush_issue_stall", {31'd0, ex_stall}, 32'd0);
    tick();
    check("flush_issue_bubble", {31'd0, MEM_valid}, 32'd0);
    issue_alu("after_flush_issue", 4'd0, 32'd2, 32'd0, 32'd3, 1'b1, 2'b00, 2'b00, 5'd8, 1'b1, 1'b0, 1'b0, 32'd5);

    // Reset mid-BUSY
    drive_mul(32'd6, 32'd7, 2'b00, 5'd9);
    tick();
    repeat (5) tick();
    reset = 1'b1;
    clear_inputs();
    tick();
    check("rstm_stall", {31'd0, ex_stall}, 32'd0);
    check("rstm_valid", {31'd0, MEM_valid}, 32'd0);
    check("rstm_rd", {27'd0, MEM_RD}, 32'd0);
    check("rstm_res", MEM_alu_result, 32'd0);
    check("rstm_st", MEM_store_data, 32'd0);
    check("rstm_br", {31'd0, branch_taken}, 32'd0);
    reset = 1'b0;
    issue_alu("after_rst", 4'd0, 32'd10, 32'd0, 32'd1, 1'b1, 2'b00, 2'b00, 5'd10, 1'b1, 1'b0, 1'b0, 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
